// File: rtl/sd_spi_card_responder.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_card_responder
// Description : Card-side SD SPI-mode responder. Decodes 48-bit host
//               commands on mosi, answers with R1/R3/R7 on miso and streams
//               single-block reads (CMD17) fetched from an external byte
//               memory port. All logic runs on clk; spi_clk, cs and mosi are
//               oversampled through 2-flop synchronizers.
//               Optional macro SD_RESP_CRC_EN: checks CRC7 on CMD0/CMD8 and
//               sends a real CRC16-CCITT after the data block.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_card_responder #(
    parameter int          BLOCK_LEN         = 512,
    parameter int          NCR_BYTES         = 1,
    parameter int          ACMD41_BUSY_POLLS = 2,
    parameter logic [31:0] OCR_VAL           = 32'h40FF8000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         spi_clk,
    input  logic                         cs,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         data_rd_en,
    output logic [31:0]                  data_rd_addr,
    output logic [$clog2(BLOCK_LEN)-1:0] data_rd_idx,
    input  logic [7:0]                   data_rd_byte,
    output logic                         card_ready,
    output logic                         cmd_valid,
    output logic [5:0]                   cmd_index,
    output logic [31:0]                  cmd_arg
);

    localparam int                 c_idx_w    = $clog2(BLOCK_LEN);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(BLOCK_LEN - 1);
    localparam logic [3:0]         c_ncr      = 4'(NCR_BYTES);
    localparam logic [7:0]         c_polls    = 8'(ACMD41_BUSY_POLLS);

    // Card (initialization) state
    localparam logic [1:0] c_card_pwrup = 2'd0;
    localparam logic [1:0] c_card_idle  = 2'd1;
    localparam logic [1:0] c_card_ready = 2'd2;

    // Protocol (byte sequencing) state
    localparam logic [2:0] c_st_rx_cmd    = 3'd0;
    localparam logic [2:0] c_st_ncr       = 3'd1;
    localparam logic [2:0] c_st_resp      = 3'd2;
    localparam logic [2:0] c_st_data_wait = 3'd3;
    localparam logic [2:0] c_st_token     = 3'd4;
    localparam logic [2:0] c_st_data      = 3'd5;
    localparam logic [2:0] c_st_dcrc      = 3'd6;

    logic [2:0]  r_sclk_sync;
    logic [1:0]  r_cs_sync;
    logic [1:0]  r_mosi_sync;

    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx_shift;
    logic [7:0]  r_tx_shift;
    logic [7:0]  r_tx_next;
    logic        r_load_pending;
    logic        r_cap;

    logic [1:0]  r_card_state;
    logic [2:0]  r_proto;
    logic [2:0]  r_frame_cnt;
    logic [5:0]  r_cmd_idx;
    logic [31:0] r_arg;
    logic        r_app_pending;
    logic [7:0]  r_poll_cnt;
    logic [3:0]  r_ncr_cnt;
    logic [39:0] r_resp;
    logic [2:0]  r_resp_left;
    logic        r_read;
    logic        r_dcrc_cnt;

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_cs_n;
    logic        w_mosi;
    logic [7:0]  w_rx_byte;
    logic        w_idle;
    logic        w_crc_ok;

    logic        w_answer;
    logic [39:0] w_resp;
    logic [2:0]  w_resp_extra;
    logic        w_read;
    logic [1:0]  w_next_card;
    logic        w_next_app;
    logic [7:0]  w_next_poll;

`ifdef SD_RESP_CRC_EN
    logic [15:0] r_crc16;

    function automatic logic [6:0] f_crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    assign w_crc_ok = (w_rx_byte[7:1] == f_crc7({2'b01, r_cmd_idx, r_arg}));
`else
    assign w_crc_ok = 1'b1;
`endif

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_n      = r_cs_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_rx_byte   = {r_rx_shift, w_mosi};
    assign w_idle      = (r_card_state == c_card_idle);

    // Bring the host-side SPI signals into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= 3'b000;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b11;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], spi_clk};
            r_cs_sync   <= {r_cs_sync[0], cs};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
        end
    end

    // Decide the answer to a completed frame from the current card state
    always_comb begin
        w_answer     = 1'b1;
        w_resp       = {8'h04 | {7'd0, w_idle}, 32'hFFFF_FFFF};
        w_resp_extra = 3'd0;
        w_read       = 1'b0;
        w_next_card  = r_card_state;
        w_next_app   = 1'b0;
        w_next_poll  = r_poll_cnt;
        if ((r_card_state == c_card_pwrup) && (r_cmd_idx != 6'd0)) begin
            w_answer = 1'b0;
        end else begin
            case (r_cmd_idx)
                6'd0: begin
                    if (w_crc_ok) begin
                        w_resp[39:32] = 8'h01;
                        w_next_card   = c_card_idle;
                        w_next_poll   = 8'd0;
                    end else begin
                        w_resp[39:32] = 8'h08 | {7'd0, w_idle};
                    end
                end
                6'd8: begin
                    if (w_crc_ok) begin
                        w_resp = {7'd0, w_idle, 16'h0000, 4'h0,
                                  (r_arg[11:8] == 4'h1) ? 4'h1 : 4'h0, r_arg[7:0]};
                        w_resp_extra = 3'd4;
                    end else begin
                        w_resp[39:32] = 8'h08 | {7'd0, w_idle};
                    end
                end
                6'd55: begin
                    w_resp[39:32] = {7'd0, w_idle};
                    w_next_app    = 1'b1;
                end
                6'd41: begin
                    if (r_app_pending) begin
                        if (r_poll_cnt < c_polls) begin
                            w_resp[39:32] = 8'h01;
                            w_next_poll   = r_poll_cnt + 8'd1;
                        end else begin
                            w_resp[39:32] = 8'h00;
                            w_next_card   = c_card_ready;
                        end
                    end
                end
                6'd58: begin
                    w_resp = {7'd0, w_idle, (r_card_state == c_card_ready), OCR_VAL[30:0]};
                    w_resp_extra = 3'd4;
                end
                6'd17: begin
                    if (r_card_state == c_card_ready) begin
                        w_resp[39:32] = 8'h00;
                        w_read        = 1'b1;
                    end else begin
                        w_resp[39:32] = 8'h05;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bit/byte engine, protocol sequencing, card state and memory fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso           <= 1'b1;
            data_rd_en     <= 1'b0;
            data_rd_addr   <= 32'd0;
            data_rd_idx    <= '0;
            card_ready     <= 1'b0;
            cmd_valid      <= 1'b0;
            cmd_index      <= 6'd0;
            cmd_arg        <= 32'd0;
            r_bit_cnt      <= 3'd0;
            r_rx_shift     <= 7'd0;
            r_tx_shift     <= 8'hFF;
            r_tx_next      <= 8'hFF;
            r_load_pending <= 1'b0;
            r_cap          <= 1'b0;
            r_card_state   <= c_card_pwrup;
            r_proto        <= c_st_rx_cmd;
            r_frame_cnt    <= 3'd0;
            r_cmd_idx      <= 6'd0;
            r_arg          <= 32'd0;
            r_app_pending  <= 1'b0;
            r_poll_cnt     <= 8'd0;
            r_ncr_cnt      <= 4'd0;
            r_resp         <= {40{1'b1}};
            r_resp_left    <= 3'd0;
            r_read         <= 1'b0;
            r_dcrc_cnt     <= 1'b0;
`ifdef SD_RESP_CRC_EN
            r_crc16        <= 16'h0000;
`endif
        end else begin
            cmd_valid  <= 1'b0;
            data_rd_en <= 1'b0;
            r_cap      <= data_rd_en;
            // Memory data arrives one clk after the strobe; it is the next byte to send
            if (r_cap) begin
                r_tx_next <= data_rd_byte;
`ifdef SD_RESP_CRC_EN
                r_crc16   <= f_crc16_byte(r_crc16, data_rd_byte);
`endif
            end
            if (w_cs_n) begin
                r_bit_cnt      <= 3'd0;
                miso           <= 1'b1;
                r_proto        <= c_st_rx_cmd;
                r_frame_cnt    <= 3'd0;
                r_load_pending <= 1'b0;
                r_tx_shift     <= 8'hFF;
                r_tx_next      <= 8'hFF;
                r_cap          <= 1'b0;
            end else begin
                if (w_sclk_fall) begin
                    if (r_load_pending) begin
                        r_tx_shift     <= r_tx_next;
                        miso           <= r_tx_next[7];
                        r_load_pending <= 1'b0;
                    end else begin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b1};
                        miso       <= r_tx_shift[6];
                    end
                end
                if (w_sclk_rise) begin
                    r_rx_shift <= w_rx_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_load_pending <= 1'b1;
                        case (r_proto)
                            c_st_rx_cmd: begin
                                r_tx_next <= 8'hFF;
                                if (r_frame_cnt == 3'd0) begin
                                    if (w_rx_byte[7:6] == 2'b01) begin
                                        r_cmd_idx   <= w_rx_byte[5:0];
                                        r_frame_cnt <= 3'd1;
                                    end
                                end else if (r_frame_cnt < 3'd5) begin
                                    r_arg       <= {r_arg[23:0], w_rx_byte};
                                    r_frame_cnt <= r_frame_cnt + 3'd1;
                                end else begin
                                    r_frame_cnt <= 3'd0;
                                    if (w_rx_byte[0] && w_answer) begin
                                        cmd_valid     <= 1'b1;
                                        cmd_index     <= r_cmd_idx;
                                        cmd_arg       <= r_arg;
                                        r_card_state  <= w_next_card;
                                        card_ready    <= (w_next_card == c_card_ready);
                                        r_app_pending <= w_next_app;
                                        r_poll_cnt    <= w_next_poll;
                                        r_resp        <= w_resp;
                                        r_resp_left   <= w_resp_extra;
                                        r_read        <= w_read;
                                        r_ncr_cnt     <= 4'd1;
                                        r_proto       <= c_st_ncr;
                                        if (w_read) data_rd_addr <= r_arg;
                                    end
                                end
                            end
                            c_st_ncr: begin
                                if (r_ncr_cnt == c_ncr) begin
                                    r_tx_next <= r_resp[39:32];
                                    r_resp    <= {r_resp[31:0], 8'hFF};
                                    r_proto   <= c_st_resp;
                                end else begin
                                    r_tx_next <= 8'hFF;
                                    r_ncr_cnt <= r_ncr_cnt + 4'd1;
                                end
                            end
                            c_st_resp: begin
                                if (r_resp_left != 3'd0) begin
                                    r_tx_next   <= r_resp[39:32];
                                    r_resp      <= {r_resp[31:0], 8'hFF};
                                    r_resp_left <= r_resp_left - 3'd1;
                                end else begin
                                    r_tx_next <= 8'hFF;
                                    r_proto   <= r_read ? c_st_data_wait : c_st_rx_cmd;
                                end
                            end
                            c_st_data_wait: begin
                                r_tx_next <= 8'hFE;
                                r_proto   <= c_st_token;
                            end
                            c_st_token: begin
                                // First data byte is fetched while the token's last bit is out
                                data_rd_en  <= 1'b1;
                                data_rd_idx <= '0;
                                r_proto     <= c_st_data;
`ifdef SD_RESP_CRC_EN
                                r_crc16     <= 16'h0000;
`endif
                            end
                            c_st_data: begin
                                if (data_rd_idx == c_last_idx) begin
`ifdef SD_RESP_CRC_EN
                                    r_tx_next <= r_crc16[15:8];
`else
                                    r_tx_next <= 8'hFF;
`endif
                                    r_dcrc_cnt <= 1'b0;
                                    r_proto    <= c_st_dcrc;
                                end else begin
                                    data_rd_en  <= 1'b1;
                                    data_rd_idx <= data_rd_idx + 1'b1;
                                end
                            end
                            c_st_dcrc: begin
                                if (!r_dcrc_cnt) begin
`ifdef SD_RESP_CRC_EN
                                    r_tx_next <= r_crc16[7:0];
`else
                                    r_tx_next <= 8'hFF;
`endif
                                    r_dcrc_cnt <= 1'b1;
                                end else begin
                                    r_tx_next <= 8'hFF;
                                    r_proto   <= c_st_rx_cmd;
                                end
                            end
                            default: begin
                                r_tx_next <= 8'hFF;
                                r_proto   <= c_st_rx_cmd;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_card_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_spi_card_responder
// Description : Scoreboard bench for sd_spi_card_responder. The host tasks
//               push the expected miso byte for every byte clocked and the
//               expected {index, arg} for every accepted command; monitors
//               pop and compare as the card shifts bytes and pulses
//               cmd_valid / data_rd_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_spi_card_responder;

    localparam int BLOCK_LEN = 512;
    localparam int HALF      = 40;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        spi_clk = 1'b0;
    logic        cs      = 1'b1;
    logic        mosi    = 1'b1;
    logic        miso;
    logic        data_rd_en;
    logic [31:0] data_rd_addr;
    logic [8:0]  data_rd_idx;
    logic [7:0]  data_rd_byte = 8'h00;
    logic        card_ready;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    sd_spi_card_responder #(
        .BLOCK_LEN        (BLOCK_LEN),
        .NCR_BYTES        (1),
        .ACMD41_BUSY_POLLS(2),
        .OCR_VAL          (32'h40FF8000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_clk     (spi_clk),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .data_rd_en  (data_rd_en),
        .data_rd_addr(data_rd_addr),
        .data_rd_idx (data_rd_idx),
        .data_rd_byte(data_rd_byte),
        .card_ready  (card_ready),
        .cmd_valid   (cmd_valid),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg)
    );

    always #5 clk = ~clk;

    // Block memory: byte value equals the low byte of its index, one-clk latency
    always @(posedge clk) begin
        if (data_rd_en) data_rd_byte <= data_rd_idx[7:0];
    end

    typedef struct { logic [7:0] val; int tag; } exp_byte_t;
    typedef struct { logic [5:0] idx; logic [31:0] arg; } exp_cmd_t;

    exp_byte_t exp_q[$];
    exp_cmd_t  cmd_q[$];

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          byte_tag   = 0;
    int          exp_rd_idx = 0;
    int          rd_count   = 0;
    logic [31:0] exp_rd_addr = 32'd7;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

`ifdef SD_RESP_CRC_EN
    function automatic logic [15:0] ref_crc16_block();
        logic [15:0] c;
        logic [7:0]  d;
        c = 16'h0000;
        for (int n = 0; n < BLOCK_LEN; n++) begin
            d = 8'(n);
            for (int i = 7; i >= 0; i--) begin
                if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
                else              c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    // miso monitor: assemble each byte on the host sampling edge and score it
    logic [7:0] mon_shift = 8'h00;
    int         mon_bits  = 0;
    always @(posedge spi_clk) begin
        exp_byte_t e;
        mon_shift = {mon_shift[6:0], miso};
        mon_bits++;
        if (mon_bits == 8) begin
            mon_bits = 0;
            if (exp_q.size() == 0) begin
                check(1'b0, "miso_unexpected_byte", 32'(mon_shift), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check(mon_shift === e.val, $sformatf("miso_byte#%0d", e.tag), 32'(mon_shift), 32'(e.val));
            end
        end
    end

    // Command-accept and memory-strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        exp_cmd_t c;
        if (cmd_valid) begin
            if (cmd_q.size() == 0) begin
                check(1'b0, "cmd_valid_unexpected", 32'(cmd_index), 32'h0);
            end else begin
                c = cmd_q.pop_front();
                check(cmd_index == c.idx, "cmd_index", 32'(cmd_index), 32'(c.idx));
                check(cmd_arg == c.arg, "cmd_arg", cmd_arg, c.arg);
            end
        end
        if (data_rd_en) begin
            check(32'(data_rd_idx) == exp_rd_idx, "data_rd_idx", 32'(data_rd_idx), 32'(exp_rd_idx));
            check(data_rd_addr == exp_rd_addr, "data_rd_addr", data_rd_addr, exp_rd_addr);
            exp_rd_idx++;
            rd_count++;
        end
    end

    task automatic xfer(input logic [7:0] tx, input logic [7:0] exp);
        exp_byte_t e;
        e.val = exp;
        e.tag = byte_tag;
        byte_tag++;
        exp_q.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #HALF spi_clk = 1'b1;
            #HALF spi_clk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc, input bit accept);
        exp_cmd_t c;
        if (accept) begin
            c.idx = idx;
            c.arg = arg;
            cmd_q.push_back(c);
        end
        xfer({2'b01, idx}, 8'hFF);
        xfer(arg[31:24], 8'hFF);
        xfer(arg[23:16], 8'hFF);
        xfer(arg[15:8],  8'hFF);
        xfer(arg[7:0],   8'hFF);
        xfer(crc,        8'hFF);
    endtask

    task automatic resp1(input logic [7:0] r1);
        xfer(8'hFF, 8'hFF);
        xfer(8'hFF, r1);
    endtask

    task automatic read_block(input int nbytes);
        logic [15:0] crc;
        send_cmd(6'd17, 32'h0000_0007, 8'h01, 1'b1);
        resp1(8'h00);
        xfer(8'hFF, 8'hFF);
        xfer(8'hFF, 8'hFE);
        for (int i = 0; i < nbytes; i++) xfer(8'hFF, 8'(i));
        if (nbytes == BLOCK_LEN) begin
`ifdef SD_RESP_CRC_EN
            crc = ref_crc16_block();
`else
            crc = 16'hFFFF;
`endif
            xfer(8'hFF, crc[15:8]);
            xfer(8'hFF, crc[7:0]);
            xfer(8'hFF, 8'hFF);
        end
    endtask

    task automatic cs_low();
        #200 cs = 1'b0;
        #200;
    endtask

    task automatic cs_high();
        #200 cs = 1'b1;
        #200;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(miso === 1'b1, {tag, "_miso"}, 32'(miso), 32'h1);
        check(data_rd_en === 1'b0, {tag, "_data_rd_en"}, 32'(data_rd_en), 32'h0);
        check(data_rd_addr === 32'd0, {tag, "_data_rd_addr"}, data_rd_addr, 32'h0);
        check(data_rd_idx === 9'd0, {tag, "_data_rd_idx"}, 32'(data_rd_idx), 32'h0);
        check(card_ready === 1'b0, {tag, "_card_ready"}, 32'(card_ready), 32'h0);
        check(cmd_valid === 1'b0, {tag, "_cmd_valid"}, 32'(cmd_valid), 32'h0);
        check(cmd_index === 6'd0, {tag, "_cmd_index"}, 32'(cmd_index), 32'h0);
        check(cmd_arg === 32'd0, {tag, "_cmd_arg"}, cmd_arg, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;
        #100;

        // cs high: card stays silent regardless of clocking
        repeat (80) xfer(8'hFF, 8'hFF);
        check(card_ready == 1'b0, "ready_after_dummy_clocks", 32'(card_ready), 32'h0);

        cs_low();
        // PWRUP ignores anything but CMD0
        send_cmd(6'd55, 32'h0, 8'h65, 1'b0);
        resp1(8'hFF);

        send_cmd(6'd0, 32'h0, 8'h95, 1'b1);
        resp1(8'h01);
        xfer(8'hFF, 8'hFF);
        check(cmd_index == 6'd0, "cmd0_index", 32'(cmd_index), 32'h0);
        check(card_ready == 1'b0, "ready_in_idle", 32'(card_ready), 32'h0);

        send_cmd(6'd8, 32'h0000_01AA, 8'h87, 1'b1);
        resp1(8'h01);
        xfer(8'hFF, 8'h00);
        xfer(8'hFF, 8'h00);
        xfer(8'hFF, 8'h01);
        xfer(8'hFF, 8'hAA);

`ifdef SD_RESP_CRC_EN
        send_cmd(6'd8, 32'h0000_01AA, 8'h89, 1'b1);
        resp1(8'h09);
`endif

        // CMD41 without a preceding CMD55 is illegal
        send_cmd(6'd41, 32'h4000_0000, 8'h77, 1'b1);
        resp1(8'h05);
        // Reads are refused before initialization completes
        rd_count = 0;
        send_cmd(6'd17, 32'h0000_0007, 8'h01, 1'b1);
        resp1(8'h05);
        check(rd_count == 0, "no_strobes_when_not_ready", 32'(rd_count), 32'h0);

        for (int k = 0; k < 3; k++) begin
            send_cmd(6'd55, 32'h0, 8'h65, 1'b1);
            resp1(8'h01);
            send_cmd(6'd41, 32'h4000_0000, 8'h77, 1'b1);
            resp1((k < 2) ? 8'h01 : 8'h00);
        end
        check(card_ready == 1'b1, "ready_after_acmd41", 32'(card_ready), 32'h1);

        send_cmd(6'd58, 32'h0, 8'hFD, 1'b1);
        resp1(8'h00);
        xfer(8'hFF, 8'hC0);
        xfer(8'hFF, 8'hFF);
        xfer(8'hFF, 8'h80);
        xfer(8'hFF, 8'h00);

        // Full block read
        rd_count   = 0;
        exp_rd_idx = 0;
        read_block(BLOCK_LEN);
        check(rd_count == BLOCK_LEN, "block_strobe_count", 32'(rd_count), 32'(BLOCK_LEN));

        // Abort mid-block with cs, then restart cleanly
        exp_rd_idx = 0;
        read_block(100);
        cs_high();
        check(card_ready == 1'b1, "ready_kept_after_abort", 32'(card_ready), 32'h1);
        exp_rd_idx = 0;
        cs_low();
        read_block(32);

        // Reset in the middle of a block
        rst = 1'b1;
        #30 check_reset_outputs("midblock_reset");
        @(negedge clk) rst = 1'b0;
        cs_high();
        cs_low();
        send_cmd(6'd17, 32'h0000_0007, 8'h01, 1'b0);
        resp1(8'hFF);
        check(card_ready == 1'b0, "ready_after_reset", 32'(card_ready), 32'h0);
        cs_high();

        check(cmd_q.size() == 0, "cmd_queue_drained", 32'(cmd_q.size()), 32'h0);
        check(exp_q.size() == 0, "byte_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
